// File: rtl/pattern_det_param.sv
// rtl/pattern_det_param.sv - serial bit-stream pattern detector with per-frame match count
//
// Purpose: scans frames of FRAME_LEN valid bits for a runtime-loaded PAT_W-bit
// pattern (MSB = first bit received), in overlapping or non-overlapping mode.
// Optional feature macro: PATTERN_DET_MASK_EN (adds i_mask; mask bit 0 = don't-care).
//
// Ports:
//   i_clk, i_rst_n  clock / synchronous active-low reset
//   i_start         start a frame (accepted in IDLE only)
//   i_pattern       pattern, latched on accepted start
//   i_overlap       1 = overlapping matches, latched on accepted start
//   i_mask          compare mask, latched on accepted start (PATTERN_DET_MASK_EN only)
//   i_valid, i_bit  qualified serial data
//   o_busy          high while scanning (RUN)
//   o_match         one-cycle pulse per match, one cycle after the matching bit
//   o_match_cnt     saturating matches in current/last frame
//   o_frame_done    one-cycle pulse after the last bit of the frame
module pattern_det_param #(
  parameter int PAT_W     = 3,
  parameter int FRAME_LEN = 32,
  parameter int CNT_W     = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [PAT_W-1:0] i_pattern,
  input  logic             i_overlap,
`ifdef PATTERN_DET_MASK_EN
  input  logic [PAT_W-1:0] i_mask,
`endif
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_busy,
  output logic             o_match,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_frame_done
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam int BC_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [BC_W-1:0]   BC_LAST   = BC_W'(FRAME_LEN - 1);

  generate
    if (PAT_W < 2 || PAT_W > 32 || PAT_W > FRAME_LEN) begin : g_param_check
      $error("pattern_det_param: illegal PAT_W / FRAME_LEN combination");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PAT_W-1:0]   r_window;
  logic [FILL_W-1:0]  r_fill;
  logic [BC_W-1:0]    r_bitcnt;
  logic [PAT_W-1:0]   r_pattern;
  logic               r_overlap;
  logic               r_match;
  logic [CNT_W-1:0]   r_cnt;

  logic [PAT_W-1:0]   w_window_next;
  logic [FILL_W-1:0]  w_fill_next;
  logic [PAT_W-1:0]   w_diff;
  logic               w_shift;
  logic               w_last;
  logic               w_hit;
  logic               w_accept;

`ifdef PATTERN_DET_MASK_EN
  logic [PAT_W-1:0]   r_mask;
  assign w_diff = (w_window_next ^ r_pattern) & r_mask;
`else
  assign w_diff = w_window_next ^ r_pattern;
`endif

  assign w_accept      = (r_state == S_IDLE) && i_start;
  assign w_shift       = (r_state == S_RUN) && i_valid;
  assign w_last        = w_shift && (r_bitcnt == BC_LAST);
  assign w_window_next = {r_window[PAT_W-2:0], i_bit};
  assign w_fill_next   = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
  // A hit needs PAT_W bits of the current frame (since the last non-overlap hit).
  assign w_hit         = (w_fill_next == FILL_FULL) && (w_diff == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    o_busy       = (r_state == S_RUN);
    o_frame_done = (r_state == S_DONE);
  end

  assign o_match     = r_match;
  assign o_match_cnt = r_cnt;

  // Datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_window  <= '0;
      r_fill    <= '0;
      r_bitcnt  <= '0;
      r_pattern <= '0;
      r_overlap <= 1'b0;
      r_match   <= 1'b0;
      r_cnt     <= '0;
`ifdef PATTERN_DET_MASK_EN
      r_mask    <= '0;
`endif
    end else begin
      r_match <= w_shift && w_hit;
      if (w_accept) begin
        r_pattern <= i_pattern;
        r_overlap <= i_overlap;
`ifdef PATTERN_DET_MASK_EN
        r_mask    <= i_mask;
`endif
        r_window  <= '0;
        r_fill    <= '0;
        r_bitcnt  <= '0;
        r_cnt     <= '0;
      end else if (w_shift) begin
        r_window <= w_window_next;
        r_bitcnt <= w_last ? '0 : r_bitcnt + BC_W'(1);
        if (w_hit) begin
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          // Non-overlap mode demands PAT_W fresh bits before the next hit.
          r_fill <= r_overlap ? FILL_FULL : '0;
        end else begin
          r_fill <= w_fill_next;
        end
      end
    end
  end

endmodule
